// File: rtl/mxm_pkg.sv
// Shared sizing helpers and the result clamp/wrap function for the mxm_stream engine.
package mxm_pkg;

    // Widest intermediate the clamp function works on; accumulators must fit in it.
    localparam int WIDE_W = 64;

    // Beat counter / inner-length width: holds 0..NMAX inclusive.
    function automatic int cnt_width(input int nmax);
        return $clog2(nmax) + 1;
    endfunction

    // Accumulator width: full product plus headroom for NMAX additions.
    function automatic int acc_width(input int w, input int nmax);
        return 2 * w + $clog2(nmax);
    endfunction

    // Returns s clamped to the w-bit signed range when sat is set, otherwise s
    // untouched (caller keeps the low w bits to wrap). ovf flags any value that
    // does not fit in w signed bits, whichever mode is selected.
    function automatic logic signed [WIDE_W-1:0] sat_wrap(
        input  logic signed [WIDE_W-1:0] s,
        input  int                       w,
        input  logic                     sat,
        output logic                     ovf
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        ovf = (s > hi) || (s < lo);
        if (sat && (s > hi))
            sat_wrap = hi;
        else if (sat && (s < lo))
            sat_wrap = lo;
        else
            sat_wrap = s;
    endfunction

endpackage

// File: rtl/mxm_mac_lane.sv
// One multiply-accumulate lane: product, running sum, output scaling and
// saturate/wrap. The lane presents the finished result combinationally on the
// last beat; the top registers it.
module mxm_mac_lane
    import mxm_pkg::*;
#(
    parameter int W    = 8,
    parameter int NMAX = 16,
    parameter int FRAC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                beat,
    input  logic                first,
    input  logic                sat,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] x,
    output logic        [W-1:0] y_res,
    output logic                ovf_res
);

    localparam int ACC_W = acc_width(W, NMAX);

    logic signed [2*W-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [WIDE_W-1:0] wide;
    logic signed [WIDE_W-1:0] clipped;
    logic                     lane_unused;

    assign prod     = a * x;
    assign prod_ext = {{(ACC_W - 2*W){prod[2*W-1]}}, prod};

    // First beat of a vector starts the sum from the product, so no clear cycle.
    assign sum     = first ? prod_ext : acc + prod_ext;
    assign shifted = sum >>> FRAC;
    assign wide    = {{(WIDE_W - ACC_W){shifted[ACC_W-1]}}, shifted};

    // Clamp or wrap the scaled sum down to the output width.
    always_comb begin
        ovf_res = 1'b0;
        clipped = sat_wrap(wide, W, sat, ovf_res);
        y_res   = clipped[W-1:0];
    end

    // Upper bits only matter through ovf_res.
    assign lane_unused = ^clipped[WIDE_W-1:W];

    // Running sum advances only on accepted beats, so a stall freezes it.
    always_ff @(posedge clk) begin
        if (!rst)
            acc <= '0;
        else if (beat)
            acc <= sum;
    end

endmodule

// File: rtl/mxm_stream.sv
// Streaming L-lane dot-product engine: beat counter, per-vector length/mode
// capture, valid/ready handshake and the single output register.
module mxm_stream
    import mxm_pkg::*;
#(
    parameter int W    = 8,
    parameter int L    = 2,
    parameter int NMAX = 16,
    parameter int FRAC = 0,
    localparam int CW  = cnt_width(NMAX)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CW-1:0]   n_len,
    input  logic            sat_en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [L*W-1:0]  x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [L*W-1:0]  y,
    output logic [L-1:0]    ovf
);

    logic [CW-1:0]  cnt;
    logic [CW-1:0]  n_cur;
    logic [CW-1:0]  n_clip;
    logic [CW-1:0]  n_eff;
    logic           sat_cur;
    logic           sat_eff;
    logic           fire;
    logic           first;
    logic           last;
    logic [L*W-1:0] y_res;
    logic [L-1:0]   ovf_res;

    // A beat can enter whenever the result register is empty or being drained.
    assign in_ready = ~out_valid | out_ready;
    assign fire     = in_valid & in_ready;
    assign first    = (cnt == '0);

    // Length of zero is treated as one; anything past NMAX is capped.
    always_comb begin
        n_clip = n_len;
        if (n_len == '0)
            n_clip = CW'(1);
        else if (n_len > CW'(NMAX))
            n_clip = CW'(NMAX);
    end

    // On the first beat the live inputs govern, so a length-1 vector finishes at once.
    assign n_eff   = first ? n_clip : n_cur;
    assign sat_eff = first ? sat_en : sat_cur;
    assign last    = (cnt == n_eff - CW'(1));

    for (genvar l = 0; l < L; l++) begin : g_lane
        mxm_mac_lane #(
            .W    (W),
            .NMAX (NMAX),
            .FRAC (FRAC)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .beat    (fire),
            .first   (first),
            .sat     (sat_eff),
            .a       (a),
            .x       (x[l*W +: W]),
            .y_res   (y_res[l*W +: W]),
            .ovf_res (ovf_res[l])
        );
    end

    // Beat counter with per-vector capture of length and saturation mode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            n_cur   <= '0;
            sat_cur <= 1'b0;
        end else if (fire) begin
            cnt <= last ? '0 : cnt + CW'(1);
            if (first) begin
                n_cur   <= n_clip;
                sat_cur <= sat_en;
            end
        end
    end

    // Output register: loads on a last beat, otherwise empties on handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= '0;
        end else if (fire && last) begin
            out_valid <= 1'b1;
            y         <= y_res;
            ovf       <= ovf_res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mxm_stream.sv
// Self-checking bench for mxm_stream: directed table, backpressure and reset
// sequences, then randomized vectors against an arithmetic reference model.
module tb_mxm_stream;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int NM = 16;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [CW-1:0]  n_len = '0;
    logic           sat_en = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   a = '0;
    logic [L*W-1:0] x = '0;
    logic           out_ready = 1'b1;
    logic           in_ready, out_valid, in_ready7, out_valid7;
    logic [L*W-1:0] y, y7;
    logic [L-1:0]   ovf, ovf7;

    mxm_stream #(.W(W), .L(L), .NMAX(NM), .FRAC(0)) dut (
        .clk(clk), .rst(rst), .n_len(n_len), .sat_en(sat_en),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
    );

    mxm_stream #(.W(W), .L(L), .NMAX(NM), .FRAC(7)) dut7 (
        .clk(clk), .rst(rst), .n_len(n_len), .sat_en(sat_en),
        .in_valid(in_valid), .in_ready(in_ready7), .a(a), .x(x),
        .out_valid(out_valid7), .out_ready(out_ready), .y(y7), .ovf(ovf7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y0, y1, z0, z1;
        logic [1:0] ovf, ovfz;
    } res_t;

    typedef struct {
        int         nl;
        int         nafter;
        bit         sat;
        int         av[4];
        int         x0v[4];
        int         x1v[4];
        logic [7:0] y0, y1;
        logic [1:0] ovf;
        logic [7:0] z0, z1;
        logic [1:0] ovfz;
    } vec_t;

    res_t exp_q[$];
    res_t r;
    int   checks = 0;
    int   errors = 0;
    int   ba[16], bx0[16], bx1[16];
    bit   bp_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int clip_n(input int nl);
        if (nl == 0) return 1;
        if (nl > NM) return NM;
        return nl;
    endfunction

    function automatic void fold(input int s, input bit sat, output logic [7:0] yy, output logic o);
        o = (s > 127) || (s < -128);
        if (sat && s > 127)       yy = 8'h7F;
        else if (sat && s < -128) yy = 8'h80;
        else                      yy = 8'(s);
    endfunction

    // Reference: plain dot products over the beat arrays, then scale and fit.
    function automatic res_t model(input bit sat, input int nb);
        res_t m;
        int s0, s1;
        s0 = 0;
        s1 = 0;
        for (int i = 0; i < nb; i++) begin
            s0 += ba[i] * bx0[i];
            s1 += ba[i] * bx1[i];
        end
        fold(s0, sat, m.y0, m.ovf[0]);
        fold(s1, sat, m.y1, m.ovf[1]);
        fold(s0 >>> 7, sat, m.z0, m.ovfz[0]);
        fold(s1 >>> 7, sat, m.z1, m.ovfz[1]);
        return m;
    endfunction

    // Results are compared just before the handshake edge that consumes them.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got y=%h with nothing expected", y);
            end else begin
                r = exp_q.pop_front();
                check("y0", 32'(y[7:0]), 32'(r.y0));
                check("y1", 32'(y[15:8]), 32'(r.y1));
                check("ovf", 32'(ovf), 32'(r.ovf));
                check("frac7_valid", 32'(out_valid7), 32'd1);
                check("frac7_y0", 32'(y7[7:0]), 32'(r.z0));
                check("frac7_y1", 32'(y7[15:8]), 32'(r.z1));
                check("frac7_ovf", 32'(ovf7), 32'(r.ovfz));
            end
        end
    end

    // Presents nbeats beats from the beat arrays; n_len/sat_en only carry the
    // real values on the first beat so later changes must be ignored.
    task automatic send(input int nl, input int nafter, input bit sat, input bit push,
                        input int nbeats, input res_t ex, input bit gaps);
        bit acc_now;
        bit done;
        int guard;
        if (push) exp_q.push_back(ex);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            a        = 8'(ba[i]);
            x        = {8'(bx1[i]), 8'(bx0[i])};
            n_len    = CW'((i == 0) ? nl : nafter);
            sat_en   = (i == 0) ? sat : ~sat;
            done     = 1'b0;
            guard    = 0;
            while (!done) begin
                @(negedge clk);
                acc_now = in_ready;
                @(posedge clk);
                #1;
                guard++;
                if (acc_now) begin
                    done = 1'b1;
                end else if (guard > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_accept_timeout: beat %0d not taken, in_ready=%b", i, in_ready);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 300) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load_beats(input vec_t v, input int nb);
        for (int i = 0; i < nb; i++) begin
            ba[i]  = v.av[i > 3 ? 3 : i];
            bx0[i] = v.x0v[i > 3 ? 3 : i];
            bx1[i] = v.x1v[i > 3 ? 3 : i];
        end
    endtask

    vec_t tbl[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t   ex;
        int     nb;
        longint t0;

        tbl = '{
            '{4, 4, 1'b1, '{1, 2, 3, 4},     '{1, 1, 1, 1},     '{2, 2, 2, 2},     8'h0A, 8'h14, 2'b00, 8'h00, 8'h00, 2'b00},
            '{3, 3, 1'b1, '{-3, -3, -3, -3}, '{5, 5, 5, 5},     '{0, 0, 0, 0},     8'hD3, 8'h00, 2'b00, 8'hFF, 8'h00, 2'b00},
            '{2, 2, 1'b1, '{127, 127, 127, 127}, '{127, 127, 127, 127}, '{-1, -1, -1, -1}, 8'h7F, 8'h80, 2'b11, 8'h7F, 8'hFE, 2'b01},
            '{2, 2, 1'b0, '{127, 127, 127, 127}, '{127, 127, 127, 127}, '{-1, -1, -1, -1}, 8'h02, 8'h02, 2'b11, 8'hFC, 8'hFE, 2'b01},
            '{4, 2, 1'b1, '{1, 1, 1, 1},     '{1, 2, 3, 4},     '{1, 1, 1, 1},     8'h0A, 8'h04, 2'b00, 8'h00, 8'h00, 2'b00},
            '{2, 2, 1'b1, '{2, 3, 3, 3},     '{1, 1, 1, 1},     '{-1, -1, -1, -1}, 8'h05, 8'hFB, 2'b00, 8'h00, 8'hFF, 2'b00},
            '{0, 0, 1'b1, '{5, 5, 5, 5},     '{-7, -7, -7, -7}, '{3, 3, 3, 3},     8'hDD, 8'h0F, 2'b00, 8'hFF, 8'h00, 2'b00},
            '{1, 1, 1'b1, '{-128, -128, -128, -128}, '{-128, -128, -128, -128}, '{1, 1, 1, 1}, 8'h7F, 8'h80, 2'b01, 8'h7F, 8'hFF, 2'b01},
            '{16, 16, 1'b1, '{-1, -1, -1, -1}, '{8, 8, 8, 8},   '{-8, -8, -8, -8}, 8'h80, 8'h7F, 2'b10, 8'hFF, 8'h01, 2'b00},
            '{20, 20, 1'b1, '{1, 1, 1, 1},   '{1, 1, 1, 1},     '{-1, -1, -1, -1}, 8'h10, 8'hF0, 2'b00, 8'h00, 8'hFF, 2'b00}
        };

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y", 32'(y), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed table, back-to-back, with per-vector beat-count timing.
        for (int t = 0; t < 10; t++) begin
            nb = clip_n(tbl[t].nl);
            load_beats(tbl[t], nb);
            ex.y0 = tbl[t].y0;   ex.y1 = tbl[t].y1;   ex.ovf = tbl[t].ovf;
            ex.z0 = tbl[t].z0;   ex.z1 = tbl[t].z1;   ex.ovfz = tbl[t].ovfz;
            t0 = $time;
            send(tbl[t].nl, tbl[t].nafter, tbl[t].sat, 1'b1, nb, ex, 1'b0);
            check("beat_cycles", 32'(($time - t0) / 10), 32'(nb));
        end
        drain();

        // Backpressure: hold the result for 5 cycles with the next vector waiting.
        out_ready = 1'b0;
        load_beats(tbl[0], 4);
        ex.y0 = 8'h0A; ex.y1 = 8'h14; ex.ovf = 2'b00; ex.z0 = 8'h00; ex.z1 = 8'h00; ex.ovfz = 2'b00;
        send(4, 4, 1'b1, 1'b1, 4, ex, 1'b0);
        load_beats(tbl[5], 2);
        ex.y0 = 8'h05; ex.y1 = 8'hFB; ex.ovf = 2'b00; ex.z0 = 8'h00; ex.z1 = 8'hFF; ex.ovfz = 2'b00;
        fork
            send(2, 2, 1'b1, 1'b1, 2, ex, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_y", 32'(y), 32'h140A);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a vector discards the partial sums.
        for (int i = 0; i < 4; i++) begin ba[i] = 1; bx0[i] = 1; bx1[i] = 1; end
        send(4, 4, 1'b1, 1'b0, 2, ex, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        ex.y0 = 8'h04; ex.y1 = 8'h04; ex.ovf = 2'b00; ex.z0 = 8'h00; ex.z1 = 8'h00; ex.ovfz = 2'b00;
        send(4, 4, 1'b1, 1'b1, 4, ex, 1'b0);
        drain();

        // Reset also discards an unread result.
        out_ready = 1'b0;
        send(4, 4, 1'b1, 1'b0, 4, ex, 1'b0);
        @(negedge clk);
        check("unread_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("unread_cleared", 32'(out_valid), 32'd0);
        check("unread_y", 32'(y), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Randomized vectors with input gaps and random backpressure.
        bp_done = 1'b0;
        fork
            begin
                for (int v = 0; v < 40; v++) begin
                    int nl, na;
                    bit sat;
                    nl  = $urandom_range(0, 20);
                    na  = $urandom_range(0, 20);
                    sat = 1'($urandom_range(0, 1));
                    nb  = clip_n(nl);
                    for (int i = 0; i < nb; i++) begin
                        ba[i]  = $urandom_range(0, 255) - 128;
                        bx0[i] = $urandom_range(0, 255) - 128;
                        bx1[i] = $urandom_range(0, 255) - 128;
                    end
                    ex = model(sat, nb);
                    send(nl, na, sat, 1'b1, nb, ex, 1'b1);
                end
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
